// File: rtl/axi_adapter_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_adapter_arbiter_if
//   Bundles the requester-side and adapter-side signals of the axi_adapter
//   arbiter. Signal suffixes are from the arbiter's point of view (_i enters
//   the arbiter, _o leaves it).
//
//   Requester side : req_i, type_i, addr_i, we_i, wdata_i, be_i, size_i, id_i
//                    gnt_o, valid_o, rdata_o, id_o, critical_word_o,
//                    critical_word_valid_o, err_o
//   Adapter side   : adp_req_o, adp_type_o, adp_addr_o, adp_we_o, adp_wdata_o,
//                    adp_be_o, adp_size_o, adp_id_o
//                    adp_gnt_i, adp_valid_i, adp_rdata_i, adp_id_i, adp_cw_i,
//                    adp_cw_valid_i
//
//   modport slave  : the arbiter
//   modport master : the environment (requesters + adapter)
// ---------------------------------------------------------------------------
interface axi_adapter_arbiter_if #(
  parameter int NUM_PORTS    = 3,
  parameter int DATA_WIDTH   = 256,
  parameter int AXI_ID_WIDTH = 10,
  parameter int XLEN         = 64
);
  // requester -> arbiter (type: 0 = single request, 1 = cache-line request)
  logic [NUM_PORTS-1:0]                     req_i;
  logic [NUM_PORTS-1:0]                     type_i;
  logic [NUM_PORTS-1:0][XLEN-1:0]           addr_i;
  logic [NUM_PORTS-1:0]                     we_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i;
  logic [NUM_PORTS-1:0][1:0]                size_i;
  logic [NUM_PORTS-1:0][AXI_ID_WIDTH-1:0]   id_i;
  // arbiter -> requester
  logic [NUM_PORTS-1:0]                     gnt_o;
  logic [NUM_PORTS-1:0]                     valid_o;
  logic [DATA_WIDTH-1:0]                    rdata_o;
  logic [AXI_ID_WIDTH-1:0]                  id_o;
  logic [XLEN-1:0]                          critical_word_o;
  logic [NUM_PORTS-1:0]                     critical_word_valid_o;
  logic                                     err_o;
  // arbiter -> adapter
  logic                                     adp_req_o;
  logic                                     adp_type_o;
  logic [XLEN-1:0]                          adp_addr_o;
  logic                                     adp_we_o;
  logic [DATA_WIDTH-1:0]                    adp_wdata_o;
  logic [DATA_WIDTH/8-1:0]                  adp_be_o;
  logic [1:0]                               adp_size_o;
  logic [AXI_ID_WIDTH-1:0]                  adp_id_o;
  // adapter -> arbiter
  logic                                     adp_gnt_i;
  logic                                     adp_valid_i;
  logic [DATA_WIDTH-1:0]                    adp_rdata_i;
  logic [AXI_ID_WIDTH-1:0]                  adp_id_i;
  logic [XLEN-1:0]                          adp_cw_i;
  logic                                     adp_cw_valid_i;

  modport slave (
    input  req_i, type_i, addr_i, we_i, wdata_i, be_i, size_i, id_i,
    output gnt_o, valid_o, rdata_o, id_o, critical_word_o,
           critical_word_valid_o, err_o,
    output adp_req_o, adp_type_o, adp_addr_o, adp_we_o, adp_wdata_o,
           adp_be_o, adp_size_o, adp_id_o,
    input  adp_gnt_i, adp_valid_i, adp_rdata_i, adp_id_i, adp_cw_i,
           adp_cw_valid_i
  );

  modport master (
    output req_i, type_i, addr_i, we_i, wdata_i, be_i, size_i, id_i,
    input  gnt_o, valid_o, rdata_o, id_o, critical_word_o,
           critical_word_valid_o, err_o,
    input  adp_req_o, adp_type_o, adp_addr_o, adp_we_o, adp_wdata_o,
           adp_be_o, adp_size_o, adp_id_o,
    output adp_gnt_i, adp_valid_i, adp_rdata_i, adp_id_i, adp_cw_i,
           adp_cw_valid_i
  );
endinterface

// File: rtl/axi_adapter_arbiter.sv
// ---------------------------------------------------------------------------
// axi_adapter_arbiter
//   Shares one axi_adapter request port between NUM_PORTS cache-side
//   requesters. Round-robin pick in IDLE, request forwarded in SERVE, and the
//   response awaited in WAIT_RSP; exactly one transaction is in flight.
//   Adapter gnt/valid/critical-word pulses are routed combinationally to the
//   owning requester only. A watchdog sets a sticky err_o if no response
//   arrives within TIMEOUT_CYCLES (0 disables it).
//
//   Ports: clk_i, rst_ni (async, active low), bus (axi_adapter_arbiter_if.slave)
// ---------------------------------------------------------------------------
module axi_adapter_arbiter #(
  parameter int NUM_PORTS      = 3,
  parameter int DATA_WIDTH     = 256,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int XLEN           = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  axi_adapter_arbiter_if.slave    bus
);

  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SERVE, WAIT_RSP} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  rr_q, rr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;

  logic [SEL_W-1:0]  pick;
  logic              pick_valid;

  logic [XLEN-1:0]           addr_mux;
  logic [DATA_WIDTH-1:0]     wdata_mux;
  logic [DATA_WIDTH/8-1:0]   be_mux;
  logic [AXI_ID_WIDTH-1:0]   id_mux;

  // Port index arithmetic wraps at NUM_PORTS, which need not be a power of 2.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[SEL_W-1:0];
  endfunction

  // Round-robin scan: first requesting port at rr_q, rr_q+1, ...
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!pick_valid && bus.req_i[wrap_add(rr_q, i)]) begin
        pick       = wrap_add(rr_q, i);
        pick_valid = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = pick;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (bus.adp_gnt_i) begin
          rr_d    = wrap_add(sel_q, 1);
          wd_d    = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.adp_valid_i) begin
          state_d = IDLE;
        end else begin
          // Counts WAIT_RSP cycles; the error is sticky and the FSM keeps waiting.
          if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
          if (TIMEOUT_CYCLES != 0 && wd_d == WD_MAX) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Payload stays muxed from sel_q through WAIT_RSP because the adapter
  // re-reads type/wdata/be after its grant. In IDLE everything is zero.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    be_mux    = '0;
    id_mux    = '0;
    bus.adp_type_o = 1'b0;
    bus.adp_we_o   = 1'b0;
    bus.adp_size_o = '0;
    if (state_q != IDLE) begin
      addr_mux       = bus.addr_i[sel_q];
      wdata_mux      = bus.wdata_i[sel_q];
      be_mux         = bus.be_i[sel_q];
      id_mux         = bus.id_i[sel_q];
      bus.adp_type_o = bus.type_i[sel_q];
      bus.adp_we_o   = bus.we_i[sel_q];
      bus.adp_size_o = bus.size_i[sel_q];
    end
    bus.adp_req_o   = (state_q == SERVE);
    bus.adp_addr_o  = addr_mux;
    bus.adp_wdata_o = wdata_mux;
    bus.adp_be_o    = be_mux;
    bus.adp_id_o    = id_mux;
  end

  // Response routing: only the owner sees pulses; stray pulses are dropped.
  always_comb begin
    bus.gnt_o                 = '0;
    bus.valid_o               = '0;
    bus.critical_word_valid_o = '0;
    bus.rdata_o               = '0;
    bus.id_o                  = '0;
    bus.critical_word_o       = '0;
    if (state_q == SERVE && bus.adp_gnt_i) bus.gnt_o[sel_q] = 1'b1;
    if (state_q == WAIT_RSP) begin
      bus.rdata_o         = bus.adp_rdata_i;
      bus.id_o            = bus.adp_id_i;
      bus.critical_word_o = bus.adp_cw_i;
      if (bus.adp_valid_i)    bus.valid_o[sel_q]               = 1'b1;
      if (bus.adp_cw_valid_i) bus.critical_word_valid_o[sel_q] = 1'b1;
    end
    bus.err_o = err_q;
  end

  // Protocol checks
  a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != WAIT_RSP) |-> !(bus.adp_valid_i || bus.adp_cw_valid_i))
    else $error("adapter response pulse outside WAIT_RSP was dropped");

  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == SERVE) |-> bus.req_i[sel_q])
    else $error("requester dropped req_i before its grant");

endmodule

// File: tb/tb_axi_adapter_arbiter.sv
module tb_axi_adapter_arbiter;
  localparam int NP  = 3;
  localparam int DW  = 256;
  localparam int IDW = 10;
  localparam int XL  = 64;
  localparam int TO  = 16;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  axi_adapter_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW), .XLEN(XL)) bus ();

  axi_adapter_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO), .XLEN(XL)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  typedef struct { int port; logic [DW-1:0] data; logic [IDW-1:0] id; } rsp_t;
  typedef struct { int port; logic [XL-1:0] word; } cw_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   gnt_q[$];
  rsp_t rsp_q[$];
  cw_t  cw_q[$];

  logic [NP-1:0] keep;
  logic [NP-1:0] we_cfg;
  logic [NP-1:0] type_cfg;
  int last_req_cyc, last_gnt_cyc, last_valid_cyc;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XL-1:0]  port_addr(input int p);  return 64'h8000_1000 + 64'(p) * 64'h40; endfunction
  function automatic logic [IDW-1:0] port_id(input int p);    return 10'h3c0 | 10'(p); endfunction
  function automatic logic [DW-1:0]  port_wdata(input int p); return {8{32'hCAFE_0000 | 32'(p)}}; endfunction
  function automatic logic [1:0]     port_size(input int p);  return 2'(p + 1); endfunction

  // Scoreboard: pulses popped against expectations pushed by the stimulus.
  int   mp;
  rsp_t mr;
  cw_t  mc;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus.gnt_o != '0) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", bus.gnt_o, 0);
        else begin
          mp = gnt_q.pop_front();
          check("gnt_port", bus.gnt_o, 3'b001 << mp);
        end
      end
      if (bus.valid_o != '0) begin
        if (rsp_q.size() == 0) check("valid_unexpected", bus.valid_o, 0);
        else begin
          mr = rsp_q.pop_front();
          check("valid_port", bus.valid_o, 3'b001 << mr.port);
          check("rdata", bus.rdata_o, mr.data);
          check("rsp_id", bus.id_o, mr.id);
        end
      end
      if (bus.critical_word_valid_o != '0) begin
        if (cw_q.size() == 0) check("cw_unexpected", bus.critical_word_valid_o, 0);
        else begin
          mc = cw_q.pop_front();
          check("cw_port", bus.critical_word_valid_o, 3'b001 << mc.port);
          check("cw_word", bus.critical_word_o, mc.word);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Adapter model for one transaction. rsp_delay <= 0 means no response.
  task automatic run_txn(input int exp_port, input int gnt_delay, input int rsp_delay,
                         input int cw_beat, input logic [DW-1:0] rdata, input logic [IDW-1:0] rid);
    int   waited;
    rsp_t r;
    cw_t  c;
    waited = 0;
    @(negedge clk_i);
    while (!bus.adp_req_o && waited < 64) begin
      @(negedge clk_i);
      waited++;
    end
    if (!bus.adp_req_o) begin
      check("adp_req_wait", bus.adp_req_o, 1);
      return;
    end
    last_req_cyc = cyc;
    check("adp_payload",
          {bus.adp_we_o, bus.adp_type_o, bus.adp_size_o, bus.adp_id_o, bus.adp_addr_o},
          {we_cfg[exp_port], type_cfg[exp_port], port_size(exp_port), port_id(exp_port), port_addr(exp_port)});
    check("adp_wdata", bus.adp_wdata_o, port_wdata(exp_port));
    gnt_q.push_back(exp_port);
    repeat (gnt_delay) next_cycle();
    bus.adp_gnt_i = 1'b1;
    @(negedge clk_i);
    last_gnt_cyc = cyc;
    check("gnt_same_cycle", bus.gnt_o, 3'b001 << exp_port);
    next_cycle();
    bus.adp_gnt_i = 1'b0;
    if (!keep[exp_port]) bus.req_i[exp_port] = 1'b0;
    if (rsp_delay <= 0) return;
    for (int k = 1; k < rsp_delay; k++) begin
      if (k == cw_beat) begin
        c.port = exp_port;
        c.word = 64'hC0DE_0000_0000_0000 | 64'(rid);
        cw_q.push_back(c);
        bus.adp_cw_valid_i = 1'b1;
        bus.adp_cw_i       = c.word;
      end
      next_cycle();
      bus.adp_cw_valid_i = 1'b0;
    end
    r.port = exp_port;
    r.data = rdata;
    r.id   = rid;
    rsp_q.push_back(r);
    bus.adp_valid_i = 1'b1;
    bus.adp_rdata_i = rdata;
    bus.adp_id_i    = rid;
    @(negedge clk_i);
    last_valid_cyc = cyc;
    check("valid_same_cycle", bus.valid_o, 3'b001 << exp_port);
    next_cycle();
    bus.adp_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) next_cycle();
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got cycle %0d expected end of test", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int c0, v0, prev_valid;
    rst_ni   = 1'b0;
    keep     = '0;
    we_cfg   = '0;
    type_cfg = '0;
    bus.req_i = '0;
    bus.adp_gnt_i = 1'b0;  bus.adp_valid_i = 1'b0;  bus.adp_cw_valid_i = 1'b0;
    bus.adp_rdata_i = '0;  bus.adp_id_i = '0;       bus.adp_cw_i = '0;
    for (int p = 0; p < NP; p++) begin
      bus.addr_i[p]  = port_addr(p);
      bus.id_i[p]    = port_id(p);
      bus.wdata_i[p] = port_wdata(p);
      bus.be_i[p]    = ~32'(p);
      bus.size_i[p]  = port_size(p);
    end
    bus.we_i   = we_cfg;
    bus.type_i = type_cfg;

    // Reset state
    #12;
    check("rst_pulses", {bus.gnt_o, bus.valid_o, bus.critical_word_valid_o, bus.err_o, bus.adp_req_o}, 0);
    check("rst_adp_addr", bus.adp_addr_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // 1: port 1 single read, gnt 2 cycles after adp_req, valid 5 cycles later
    c0 = cyc;
    bus.req_i[1] = 1'b1;
    run_txn(1, 2, 5, 0, {8{32'hD000_0001}}, 10'h201);
    check("req_to_adp_req", last_req_cyc - c0, 1);

    // 2: all ports requesting continuously from rr_q=0 -> 0,1,2,0
    do_reset();
    keep = 3'b111;
    bus.req_i = 3'b111;
    prev_valid = -1;
    for (int t = 0; t < 4; t++) begin
      run_txn(t % NP, 1, 2, 0, {8{32'hD000_0010 + 32'(t)}}, 10'h210 + 10'(t));
      if (t > 0) check("b2b_gap", last_req_cyc - prev_valid, 2);
      prev_valid = last_valid_cyc;
    end
    bus.req_i = '0;
    keep = '0;

    // 3: port 2 cache-line read, critical word on beat 3
    type_cfg[2] = 1'b1;
    bus.type_i  = type_cfg;
    bus.req_i[2] = 1'b1;
    run_txn(2, 1, 6, 3, {8{32'hD000_0020}}, 10'h220);

    // 4: port 0 burst write with a late grant; port 1 waits behind it
    we_cfg[0]   = 1'b1;
    type_cfg[0] = 1'b1;
    bus.we_i    = we_cfg;
    bus.type_i  = type_cfg;
    bus.req_i   = 3'b011;
    run_txn(0, 8, 4, 0, {8{32'hD000_0030}}, 10'h230);
    v0 = last_valid_cyc;
    run_txn(1, 1, 3, 0, {8{32'hD000_0031}}, 10'h231);
    check("p1_after_p0_valid", last_req_cyc - v0, 2);

    // 5: watchdog, adapter never answers
    bus.req_i[0] = 1'b1;
    run_txn(0, 1, 0, 0, '0, '0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      check($sformatf("wd_err_k%0d", k), bus.err_o, (cyc - last_gnt_cyc) >= 17);
    end
    check("wait_rsp_held", {bus.adp_req_o, bus.adp_addr_o}, {1'b0, port_addr(0)});

    // 6: reset in WAIT_RSP, pending req_i[2] served first afterwards
    next_cycle();
    bus.req_i = 3'b100;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_async_pulses", {bus.gnt_o, bus.valid_o, bus.critical_word_valid_o, bus.err_o, bus.adp_req_o}, 0);
    check("rst_async_payload", {bus.adp_we_o, bus.adp_type_o, bus.adp_size_o, bus.adp_id_o, bus.adp_addr_o}, 0);
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
    run_txn(2, 1, 2, 0, {8{32'hD000_0040}}, 10'h240);
    check("err_after_rst", bus.err_o, 0);

    repeat (3) next_cycle();
    check("gnt_q_drained", gnt_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    check("cw_q_drained", cw_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
